uart_tx_feeder: RTL and testbench

- Upstream stage of the UART transmitter. Buffers bytes from the SDRAM read-back path in a small FIFO.
- Hands bytes to the transmitter one at a time as a 1-cycle tx_trig pulse with tx_data held stable.
- Spaces consecutive triggers by a full frame time, because the transmitter has no busy/done output.
- Sits between the SDRAM read-data path and the transmitter's tx_trig/tx_data inputs.

---
 rtl/uart_tx_feeder_pkg.sv | 30 +++
 rtl/uart_tx_fifo.sv | 76 +++++++
 rtl/uart_tx_feeder.sv | 107 ++++++++++
 tb/tb_uart_tx_feeder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: FSM state encoding and
// the default frame length, shortened for simulation builds.
package uart_tx_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } feeder_state_e;

`ifdef SIM
  localparam int FRAME_CYC_DEF = 32'd570;
`else
  localparam int FRAME_CYC_DEF = 32'd52080;
`endif

  // Next FIFO occupancy given the accepted write/read strobes.
  function automatic logic [4:0] fifo_count_next(input logic [4:0] cnt,
                                                 input logic       wr_ok,
                                                 input logic       rd_ok);
    logic [4:0] res;
    case ({wr_ok, rd_ok})
      2'b10:   res = cnt + 5'd1;
      2'b01:   res = cnt - 5'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with registered read data (1-cycle latency); writes while full
// are dropped, even when a read happens in the same cycle.
module uart_tx_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               wr_ok_s;
  logic               rd_ok_s;

  assign full    = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;
  assign rd_data = rd_data_q;

  // Pointer, occupancy and read-data next-state logic.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    if (wr_ok_s) begin
      wptr_d = wptr_q + FIFO_AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_ok_s) begin
      rptr_d    = rptr_q + FIFO_AW'(1);
      rd_data_d = mem_q[rptr_q];
    end else begin
      rptr_d    = rptr_q;
      rd_data_d = rd_data_q;
    end
    count_d = (FIFO_AW+1)'(fifo_count_next(5'(count_q), wr_ok_s, rd_ok_s));
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_data_q <= 8'h00;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Feeds buffered bytes to a UART transmitter that has no busy output:
// one tx_trig pulse per byte, spaced by a full frame time.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4,
  parameter int FRAME_CYC  = FRAME_CYC_DEF,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       tx_en,
  output logic       tx_trig,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       ovf
);

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_trig_q, tx_trig_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             ovf_q, ovf_d;
  logic             rd_en_s;
  logic [7:0]       rd_data_s;
  logic             full_s;
  logic             empty_s;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (rd_en_s),
    .rd_data(rd_data_s),
    .full   (full_s),
    .empty  (empty_s)
  );

  assign full    = full_s;
  assign tx_trig = tx_trig_q;
  assign tx_data = tx_data_q;
  assign ovf     = ovf_q;
  assign busy    = (state_q != IDLE) | ~empty_s;

  // FSM next state, frame counter and transmitter-facing outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_trig_d = 1'b0;
    tx_data_d = tx_data_q;
    rd_en_s   = 1'b0;
    ovf_d     = ovf_q | (wr_en & full_s);
    case (state_q)
      IDLE: begin
        if (tx_en && !empty_s) begin
          rd_en_s = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        tx_data_d = rd_data_s;
        tx_trig_d = 1'b1;
        cnt_d     = CNT_W'(FRAME_CYC - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_trig_q <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_trig_q <= tx_trig_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder against a transaction-timing model:
// a byte queue plus the cycle at which the next frame may start.
module tb_uart_tx_feeder;

  localparam int FRAME = 570;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       tx_en;
  logic       tx_trig;
  logic [7:0] tx_data;
  logic       busy;
  logic       ovf;

  uart_tx_feeder #(
    .FIFO_DEPTH(DEPTH),
    .FIFO_AW   (4),
    .FRAME_CYC (FRAME),
    .CNT_W     (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .full   (full),
    .tx_en  (tx_en),
    .tx_trig(tx_trig),
    .tx_data(tx_data),
    .busy   (busy),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0] q_m [$];
  int         next_free = 0;
  int         trig_cycle = -100;
  logic [7:0] pend_data = 8'h00;
  logic       exp_trig = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_ovf = 1'b0;

  // Observed trigger log
  int         trig_t [$];
  logic [7:0] trig_d [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input logic we, input logic [7:0] wd, input logic te);
    logic exp_busy;
    logic wr_ok;
    wr_en   = we;
    wr_data = wd;
    tx_en   = te;
    @(negedge clk);
    exp_busy = (cyc < next_free) || (q_m.size() != 0);
    check_eq("tx_trig", tx_trig, exp_trig);
    check_eq("tx_data", tx_data, exp_data);
    check_eq("busy", busy, exp_busy);
    check_eq("full", full, q_m.size() == DEPTH);
    check_eq("ovf", ovf, exp_ovf);
    if (tx_trig === 1'b1) begin
      trig_t.push_back(cyc);
      trig_d.push_back(tx_data);
    end
    wr_ok = we && (q_m.size() < DEPTH);
    if (we && !wr_ok) exp_ovf = 1'b1;
    if (te && q_m.size() > 0 && cyc >= next_free) begin
      pend_data  = q_m.pop_front();
      trig_cycle = cyc + 2;
      next_free  = cyc + FRAME + 2;
    end
    if (wr_ok) q_m.push_back(wd);
    @(posedge clk);
    #1;
    cyc++;
    exp_trig = (cyc == trig_cycle);
    if (exp_trig) exp_data = pend_data;
  endtask

  task automatic run_idle(input int n, input logic te);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, te);
  endtask

  int base;
  int wcyc;
  int t_en;
  logic [7:0] sent [$];
  logic te_r;

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    tx_en   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_trig", tx_trig, 1'b0);
    check_eq("rst_data", tx_data, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_full", full, 1'b0);
    check_eq("rst_ovf", ovf, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single byte
    base = trig_t.size();
    wcyc = cyc;
    step(1'b1, 8'hA5, 1'b1);
    run_idle(600, 1'b1);
    check_eq("single_cnt", trig_t.size() - base, 1);
    if (trig_t.size() > base) begin
      check_eq("single_lat", trig_t[base] - (wcyc + 1), 2);
      check_eq("single_data", trig_d[base], 8'hA5);
    end

    // Burst of three
    base = trig_t.size();
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    run_idle(1800, 1'b1);
    check_eq("burst_cnt", trig_t.size() - base, 3);
    if (trig_t.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) check_eq("burst_data", trig_d[base+i], 8'(i + 1));
      for (int i = 0; i < 2; i++) check_eq("burst_gap", trig_t[base+i+1] - trig_t[base+i], FRAME + 2);
    end

    // Overflow with transmission paused
    base = trig_t.size();
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
    check_eq("ovf_set", ovf, 1'b1);
    check_eq("ovf_full", full, 1'b1);
    run_idle(16 * (FRAME + 2) + 100, 1'b1);
    check_eq("ovf_cnt", trig_t.size() - base, 16);
    if (trig_t.size() >= base + 16) begin
      for (int i = 0; i < 16; i++) check_eq("ovf_data", trig_d[base+i], 8'(i));
    end
    check_eq("ovf_sticky", ovf, 1'b1);

    // Pause: drop tx_en just after the first trigger
    base = trig_t.size();
    step(1'b1, 8'h5A, 1'b1);
    step(1'b1, 8'hC3, 1'b1);
    run_idle(2, 1'b1);
    run_idle(1200, 1'b0);
    check_eq("pause_cnt", trig_t.size() - base, 1);
    t_en = cyc;
    run_idle(600, 1'b1);
    check_eq("resume_cnt", trig_t.size() - base, 2);
    if (trig_t.size() >= base + 2) begin
      check_eq("resume_lat", trig_t[base+1] - t_en, 2);
      check_eq("resume_data", trig_d[base+1], 8'hC3);
    end

    // Simultaneous read and write at full-1
    for (int i = 0; i < 15; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    check_eq("rw_full", full, 1'b0);
    run_idle(16 * (FRAME + 2) + 100, 1'b1);

    // Pointer wrap with paced writes
    base = trig_t.size();
    sent.delete();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      step(1'b1, b, 1'b1);
      run_idle($urandom_range(FRAME + 10, FRAME + 50), 1'b1);
    end
    run_idle(FRAME + 50, 1'b1);
    check_eq("wrap_cnt", trig_t.size() - base, 40);
    if (trig_t.size() >= base + 40) begin
      for (int i = 0; i < 40; i++) check_eq("wrap_data", trig_d[base+i], sent[i]);
    end

    // Random traffic with tx_en toggling
    te_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) te_r = ~te_r;
      step($urandom_range(0, 149) == 0, 8'($urandom_range(0, 255)), te_r);
    end
    run_idle(17 * (FRAME + 2), 1'b1);

    // Reset in the middle of a frame with bytes queued
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
    run_idle(100, 1'b1);
    wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_trig", tx_trig, 1'b0);
    check_eq("mid_rst_data", tx_data, 8'h00);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_full", full, 1'b0);
    check_eq("mid_rst_ovf", ovf, 1'b0);
    q_m.delete();
    next_free  = 0;
    trig_cycle = -100;
    exp_trig   = 1'b0;
    exp_data   = 8'h00;
    exp_ovf    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b1;
    base = trig_t.size();
    run_idle(1200, 1'b1);
    check_eq("post_rst_cnt", trig_t.size() - base, 0);
    step(1'b1, 8'h99, 1'b1);
    run_idle(600, 1'b1);
    check_eq("post_rst_new", trig_t.size() - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
